// File: rtl/note_judge_pkg.sv
// Shared encodings for the rhythm-game note judge: judgement codes, FSM states
// and the score awarded per hit grade.
package note_judge_pkg;

    typedef enum logic [1:0] {
        J_NONE    = 2'b00,
        J_GOOD    = 2'b01,
        J_PERFECT = 2'b10,
        J_MISS    = 2'b11
    } judge_t;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'b00,
        ST_JUDGE   = 2'b01,
        ST_LOCKOUT = 2'b10
    } state_t;

    localparam int unsigned PERFECT_PTS = 2;
    localparam int unsigned GOOD_PTS    = 1;

    function automatic logic is_hit(input judge_t j);
        return (j == J_PERFECT) || (j == J_GOOD);
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Per-lane two-flop synchroniser for raw active-low buttons, producing the
// pressed vector and a pulse whenever any lane goes released->pressed.
module key_sync_edge #(
    parameter int LANES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] key_n,
    output logic [LANES-1:0] pressed,
    output logic             press_edge
);

    logic [LANES-1:0] sync_p0;
    logic [LANES-1:0] sync_p1;
    logic [LANES-1:0] pressed_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0    <= '1;
            sync_p1    <= '1;
            pressed_p2 <= '0;
        end else begin
            sync_p0    <= key_n;
            sync_p1    <= sync_p0;
            pressed_p2 <= ~sync_p1;
        end
    end

    // Synchronised domain: compare current pressed lanes against last cycle's
    assign pressed    = ~sync_p1;
    assign press_edge = |(pressed & ~pressed_p2);

endmodule

// File: rtl/note_judge.sv
// Judges button presses against the head note of a note stream, pops judged
// notes, and keeps saturating score and combo totals.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int LANES       = 3,
    parameter int XW          = 9,
    parameter int PERFECT_EPS = 12,
    parameter int GOOD_EPS    = 36,
    parameter int SCORE_W     = 8,
    parameter int COMBO_W     = 8,
    localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [LANES-1:0]   key_n,
    input  logic               note_valid,
    input  logic [LW-1:0]      note_lane,
    input  logic [XW-1:0]      note_x,
    output logic               consume,
    output logic               hit,
    output logic [1:0]         judge,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo
);

    state_t           state;
    logic             guard;
    logic [LANES-1:0] pressed;
    logic             press_edge;
    logic             any_pressed;
    logic             auto_miss;
    judge_t           verdict;

    logic [LANES-1:0] press_vec_p1;
    logic [LW-1:0]    lane_p1;
    logic [XW-1:0]    note_x_p1;
    logic             vld_p1;

    function automatic logic [LANES-1:0] onehot(input logic [LW-1:0] lane);
        logic [LANES-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LW'(i) == lane) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] s,
                                                         input int unsigned pts);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(pts);
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
        return (&c) ? c : c + COMBO_W'(1);
    endfunction

    key_sync_edge #(
        .LANES(LANES)
    ) u_sync (
        .clk        (CLOCK_50),
        .reset      (reset),
        .key_n      (key_n),
        .pressed    (pressed),
        .press_edge (press_edge)
    );

    assign any_pressed = |pressed;

    // A press captured this cycle owns the head note, so the timeout miss stands down
    assign auto_miss = (state != ST_JUDGE) && !((state == ST_ARMED) && press_edge) &&
                       note_valid && (note_x == '0) && !guard;

    // Stage p1: press vector and head note captured on the press edge
    always_ff @(posedge CLOCK_50) begin
        if ((state == ST_ARMED) && press_edge) begin
            press_vec_p1 <= pressed;
            lane_p1      <= note_lane;
            note_x_p1    <= note_x;
        end
    end

    always_comb begin
        verdict = J_NONE;
        if (vld_p1 && (int'(note_x_p1) < GOOD_EPS)) begin
            if (press_vec_p1 != onehot(lane_p1)) verdict = J_MISS;
            else if (int'(note_x_p1) < PERFECT_EPS) verdict = J_PERFECT;
            else verdict = J_GOOD;
        end
    end

    // Stage p2: registered judgement pulses and running totals
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_ARMED;
            vld_p1  <= 1'b0;
            guard   <= 1'b0;
            consume <= 1'b0;
            hit     <= 1'b0;
            judge   <= J_NONE;
            score   <= '0;
            combo   <= '0;
        end else begin
            consume <= 1'b0;
            hit     <= 1'b0;
            judge   <= J_NONE;
            guard   <= 1'b0;

            case (state)
                ST_ARMED: begin
                    if (press_edge) begin
                        vld_p1 <= note_valid && !guard;
                        state  <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    vld_p1 <= 1'b0;
                    state  <= ST_LOCKOUT;
                end
                ST_LOCKOUT: begin
                    if (!any_pressed) state <= ST_ARMED;
                end
                default: state <= ST_ARMED;
            endcase

            if ((state == ST_JUDGE) && (verdict != J_NONE)) begin
                consume <= 1'b1;
                guard   <= 1'b1;
                judge   <= verdict;
                hit     <= is_hit(verdict);
                if (is_hit(verdict)) begin
                    score <= sat_add_score(score, (verdict == J_PERFECT) ? PERFECT_PTS : GOOD_PTS);
                    combo <= sat_inc_combo(combo);
                end else begin
                    combo <= '0;
                end
            end else if (auto_miss) begin
                consume <= 1'b1;
                guard   <= 1'b1;
                judge   <= J_MISS;
                combo   <= '0;
            end
        end
    end

endmodule

// File: doc/note_judge.md
NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 SHALL have parameter LANES, default 3, number of bongo/key lanes (1..8).
REQ-002 SHALL have parameter XW, default 9, width of note x-distance to hit marker.
REQ-003 SHALL have parameter PERFECT_EPS, default 12, strict upper x bound for PERFECT.
REQ-004 SHALL have parameter GOOD_EPS, default 36, strict upper x bound for GOOD (GOOD_EPS > PERFECT_EPS).
REQ-005 SHALL have parameter SCORE_W, default 8, score width; COMBO_W, default 8, combo width.
REQ-006 SHALL have port CLOCK_50, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port key_n, input, LANES, raw active-low buttons; bit i = lane i.
REQ-009 SHALL have port note_valid, input, 1, head note present.
REQ-010 SHALL have port note_lane, input, clog2(LANES), lane of head note.
REQ-011 SHALL have port note_x, input, XW, head-note distance to hit marker.
REQ-012 SHALL have port consume, output, 1, one-cycle pulse: head note judged, stream pops.
REQ-013 SHALL have port hit, output, 1, one-cycle pulse on PERFECT or GOOD.
REQ-014 SHALL have port judge, output, 2, 00 NONE, 01 GOOD, 10 PERFECT, 11 MISS; valid with consume.
REQ-015 SHALL have ports score (SCORE_W) and combo (COMBO_W), outputs, running totals.

Function
REQ-016 SHALL pass key_n through a 2-flop synchroniser per lane, then invert to pressed vector.
REQ-017 SHALL flag press edge when any synced lane goes released->pressed.
REQ-018 SHALL run FSM ARMED -> JUDGE -> LOCKOUT -> ARMED.
REQ-019 ARMED: on press edge, latch pressed vector and note inputs, go JUDGE next cycle.
REQ-020 JUDGE: lasts exactly one cycle; registered outputs appear the following cycle.
REQ-021 SHALL classify press as ignored (no consume, judge 00) when !note_valid or note_x >= GOOD_EPS.
REQ-022 SHALL classify PERFECT when latched vector equals onehot(note_lane) and note_x < PERFECT_EPS; GOOD when equal and PERFECT_EPS <= note_x < GOOD_EPS.
REQ-023 SHALL classify MISS when note in GOOD window but latched vector != onehot(note_lane) (wrong or extra key).
REQ-024 LOCKOUT: hold until all synced lanes released, then ARMED; presses in LOCKOUT ignored.
REQ-025 SHALL auto-MISS (consume, judge 11) when state != JUDGE, note_valid, note_x == 0, guard clear.
REQ-026 SHALL set a one-cycle guard after any consume; note inputs ignored while guard set.
REQ-027 Press judgement and auto-MISS same cycle: press judgement wins; single consume.
REQ-028 Score: PERFECT +2, GOOD +1, saturating at 2^SCORE_W-1; MISS/NONE unchanged.
REQ-029 Combo: +1 per hit, saturating; cleared to 0 on MISS.
REQ-030 consume, hit, judge SHALL be registered, asserted exactly one cycle, 00/0 otherwise.
REQ-031 Press-to-output latency: 2 cycles after synced edge sampled in ARMED.

Reset
REQ-032 reset SHALL clear state to ARMED, synchronisers to released, guard, consume, hit, judge, score, combo to 0.
REQ-033 reset asserted mid-JUDGE or LOCKOUT SHALL drop pending judgement; no output pulse.

Structure
REQ-034 SHALL place judge codes, FSM state encoding, score increments in shared package note_judge_pkg.
REQ-035 SHALL use one sub-module key_sync_edge (per-lane synchroniser + edge detect, width LANES).

Verification
REQ-036 Lane1 note, note_x=5, press key_n[1] -> 2 cycles after synced edge: consume=1, hit=1, judge=10, score 0->2, combo 0->1.
REQ-037 Lane0 note, note_x=20, press key_n[0] -> judge=01, score+1; then hold key, second lane press ignored until release.
REQ-038 Lane2 note, note_x=10, press key_n[0] -> judge=11, hit=0, combo cleared to 0, score unchanged.
REQ-039 note_x counts down to 0 with no press -> single consume, judge=11; guard blocks repeat next cycle.
REQ-040 score=254, PERFECT -> score=255; reset asserted during JUDGE -> no pulse, score=0, combo=0.
